// File: rtl/jailbreak_speech_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jailbreak_speech_pkg
// Description : Shared constants, gain-state encoding and DAC centring helper
//               for the VLM5030 speech conditioning path.
// Revision    : 1.0 - initial release
// ============================================================================
package jailbreak_speech_pkg;

    localparam int DIV_DEFAULT       = 256;
    localparam int RAMP_STEP_DEFAULT = 1;
    localparam int MIDSCALE          = 512;
    localparam int GAIN_MAX          = 256;

    localparam int DAC_W    = 10;
    localparam int GAIN_W   = 9;
    localparam int SCALED_W = 17;
    localparam int PROD_W   = 26;
    localparam int OUT_W    = 16;

    typedef enum logic [1:0] {
        ST_MUTE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } gain_state_e;

    // Offset-binary DAC code -> signed, centred on MIDSCALE, scaled up by 64.
    function automatic logic [SCALED_W-1:0] center_scale(input logic [DAC_W-1:0] dac);
        logic [DAC_W:0] centered;
        centered = {1'b0, dac} - (DAC_W+1)'(MIDSCALE);
        return {centered, 6'b00_0000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/jailbreak_audio_ce.sv
`default_nettype none
// ============================================================================
// Module      : jailbreak_audio_ce
// Description : Free-running clock-enable generator, one pulse every DIV clks.
// Revision    : 1.0 - initial release
// ============================================================================
module jailbreak_audio_ce #(
    parameter int DIV = 256
) (
    input  logic clk,
    input  logic reset,
    output logic ce
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    // ce is registered so the first pulse lands exactly DIV clks after release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            ce    <= 1'b0;
        end else if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_q <= '0;
            ce    <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            ce    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jailbreak_speech_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : jailbreak_speech_conditioner
// Description : Centres, scales and click-free gates VLM5030 DAC samples into
//               a signed 16-bit stream at the audio tick rate.
// Revision    : 1.0 - initial release
// ============================================================================
module jailbreak_speech_conditioner
    import jailbreak_speech_pkg::*;
#(
    parameter int DIV       = DIV_DEFAULT,
    parameter int RAMP_STEP = RAMP_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vlm_sample,
    input  logic [9:0]  vlm_dac,
    input  logic        vlm_busy,
    output logic [15:0] out,
    output logic        out_valid
);

    logic tick;

    jailbreak_audio_ce #(
        .DIV (DIV)
    ) u_ce (
        .clk   (clk),
        .reset (reset),
        .ce    (tick)
    );

    logic [DAC_W-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q <= DAC_W'(MIDSCALE);
        end else if (vlm_sample) begin
            hold_q <= vlm_dac;
        end
    end

    gain_state_e       state_q;
    logic [GAIN_W-1:0] gain_q;
    logic [GAIN_W:0]   gain_up_sum;
    logic [GAIN_W-1:0] gain_up;
    logic [GAIN_W-1:0] gain_dn;

    // One spare bit on the sum keeps the saturation compare honest for large steps.
    assign gain_up_sum = {1'b0, gain_q} + (GAIN_W+1)'(RAMP_STEP);
    assign gain_up     = (gain_up_sum >= (GAIN_W+1)'(GAIN_MAX)) ? GAIN_W'(GAIN_MAX)
                                                                : gain_up_sum[GAIN_W-1:0];
    assign gain_dn     = (gain_q <= GAIN_W'(RAMP_STEP)) ? '0 : gain_q - GAIN_W'(RAMP_STEP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_MUTE;
            gain_q  <= '0;
        end else if (tick) begin
            case (state_q)
                ST_MUTE: begin
                    if (vlm_busy) state_q <= ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (!vlm_busy) begin
                        state_q <= ST_RAMP_DOWN;
                    end else begin
                        gain_q <= gain_up;
                        if (gain_up == GAIN_W'(GAIN_MAX)) state_q <= ST_ON;
                    end
                end
                ST_ON: begin
                    if (!vlm_busy) state_q <= ST_RAMP_DOWN;
                end
                ST_RAMP_DOWN: begin
                    if (vlm_busy) begin
                        state_q <= ST_RAMP_UP;
                    end else begin
                        gain_q <= gain_dn;
                        if (gain_dn == '0) state_q <= ST_MUTE;
                    end
                end
                default: state_q <= ST_MUTE;
            endcase
        end
    end

    logic [SCALED_W-1:0]      scaled;
    logic signed [PROD_W-1:0] scaled_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] product_d;
    logic signed [PROD_W-1:0] product_q;
    logic                     prod_vld_q;

    assign scaled     = center_scale(hold_q);
    assign scaled_ext = PROD_W'($signed(scaled));
    assign gain_ext   = PROD_W'($signed({1'b0, gain_q}));
    assign product_d  = scaled_ext * gain_ext;

    // The tick samples pre-update hold/gain, so a coincident strobe lands next tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            product_q  <= '0;
            prod_vld_q <= 1'b0;
            out        <= '0;
            out_valid  <= 1'b0;
        end else begin
            prod_vld_q <= tick;
            if (tick) product_q <= product_d;
            out_valid  <= prod_vld_q;
            if (prod_vld_q) out <= OUT_W'(product_q >>> 8);
        end
    end

endmodule
`default_nettype wire
